// File: rtl/genius_round_ctrl.sv
// Round controller for the Genius (Simon) game: plays back the colour sequence,
// checks player presses against it and reports ROUND / WIN / LOSE to the scorer.
module genius_round_ctrl #(
    parameter int MAX_ROUND      = 15,
    parameter int SHOW_ON        = 4,
    parameter int SHOW_OFF       = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    output logic [3:0] SEQ_ADDR,
    input  logic [1:0] SEQ_DATA,
    input  logic       BTN_VALID,
    input  logic [1:0] BTN_CODE,
    output logic       LED_VALID,
    output logic [1:0] LED_CODE,
    output logic [3:0] ROUND,
    output logic       BUSY,
    output logic       WIN,
    output logic       LOSE
);

    localparam int T_SHOW = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
    localparam int T_SPAN = (TIMEOUT_CYCLES > T_SHOW) ? TIMEOUT_CYCLES : T_SHOW;
    localparam int TW     = ($clog2(T_SPAN) > 7) ? $clog2(T_SPAN) : 7;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON_S,
        SHOW_OFF_S,
        WAIT_INPUT,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [3:0]      idx, idx_d;
    logic [TW-1:0]   timer, timer_d;
    logic [3:0]      round, round_d;
    logic            win, win_d, lose, lose_d;
    logic            led_valid, led_valid_d, busy, busy_d;
    logic [1:0]      led_code, led_code_d;
    logic            show_last, show_last_d;
    logic [1:0]      first_code, first_code_d;
    logic [3:0]      round_inc;

    assign round_inc = round + 4'd1;

    // The LED colour is captured on the edge that enters SHOW_ON_S, so SEQ_ADDR
    // must already point at the next element one cycle early: IDX advances when
    // a lit window ends, and element 0 is remembered for the start of each round.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d      = state;
        idx_d        = idx;
        timer_d      = timer;
        round_d      = round;
        win_d        = win;
        lose_d       = lose;
        led_code_d   = led_code;
        show_last_d  = show_last;
        first_code_d = first_code;

        unique case (state)
            SHOW_ON_S: begin
                if (timer == TW'(SHOW_ON - 1)) begin
                    state_d     = SHOW_OFF_S;
                    timer_d     = '0;
                    show_last_d = (idx == round);
                    if (idx != round) idx_d = idx + 4'd1;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            SHOW_OFF_S: begin
                if (timer == TW'(SHOW_OFF - 1)) begin
                    timer_d = '0;
                    if (show_last) begin
                        state_d = WAIT_INPUT;
                        idx_d   = '0;
                    end else begin
                        state_d    = SHOW_ON_S;
                        led_code_d = SEQ_DATA;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            WAIT_INPUT: begin
                // A press in the expiry cycle wins over the timeout.
                if (BTN_VALID) begin
                    if (BTN_CODE != SEQ_DATA) begin
                        lose_d  = 1'b1;
                        state_d = DONE;
                        idx_d   = '0;
                    end else if (idx != round) begin
                        idx_d   = idx + 4'd1;
                        timer_d = '0;
                    end else begin
                        round_d = round_inc;
                        idx_d   = '0;
                        timer_d = '0;
                        if (round_inc == 4'(MAX_ROUND)) begin
                            win_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d    = SHOW_ON_S;
                            led_code_d = first_code;
                        end
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    lose_d  = 1'b1;
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: begin
                // IDLE and DONE: IDX is always 0 here, so SEQ_DATA is element 0.
                if (START) begin
                    state_d      = SHOW_ON_S;
                    round_d      = '0;
                    idx_d        = '0;
                    timer_d      = '0;
                    win_d        = 1'b0;
                    lose_d       = 1'b0;
                    led_code_d   = SEQ_DATA;
                    first_code_d = SEQ_DATA;
                end
            end
        endcase

        led_valid_d = (state_d == SHOW_ON_S);
        busy_d      = (state_d == SHOW_ON_S) || (state_d == SHOW_OFF_S) ||
                      (state_d == WAIT_INPUT);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            round      <= '0;
            win        <= 1'b0;
            lose       <= 1'b0;
            led_valid  <= 1'b0;
            led_code   <= '0;
            busy       <= 1'b0;
            show_last  <= 1'b0;
            first_code <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state      <= state_d;
            idx        <= idx_d;
            timer      <= timer_d;
            round      <= round_d;
            win        <= win_d;
            lose       <= lose_d;
            led_valid  <= led_valid_d;
            led_code   <= led_code_d;
            busy       <= busy_d;
            show_last  <= show_last_d;
            first_code <= first_code_d;
        end
    end

    assign SEQ_ADDR  = idx;
    assign LED_VALID = led_valid;
    assign LED_CODE  = led_code;
    assign ROUND     = round;
    assign BUSY      = busy;
    assign WIN       = win;
    assign LOSE      = lose;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Directed bench for genius_round_ctrl: playback timing, press checking,
// timeout boundary, win at MAX_ROUND=3 and asynchronous reset.
module tb_genius_round_ctrl;

    localparam int MAXR = 3;

    logic       CLOCK = 1'b0;
    logic       RESET, START, BTN_VALID;
    logic [1:0] BTN_CODE, SEQ_DATA, LED_CODE;
    logic [3:0] SEQ_ADDR, ROUND;
    logic       LED_VALID, BUSY, WIN, LOSE;
    logic [1:0] seq_mem [16];
    int         total = 0;
    int         bad = 0;

    assign SEQ_DATA = seq_mem[SEQ_ADDR];
    always #5 CLOCK = ~CLOCK;

    genius_round_ctrl #(
        .MAX_ROUND(MAXR), .SHOW_ON(4), .SHOW_OFF(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .SEQ_ADDR(SEQ_ADDR), .SEQ_DATA(SEQ_DATA),
        .BTN_VALID(BTN_VALID), .BTN_CODE(BTN_CODE),
        .LED_VALID(LED_VALID), .LED_CODE(LED_CODE),
        .ROUND(ROUND), .BUSY(BUSY), .WIN(WIN), .LOSE(LOSE)
    );

    // One clock; outputs are observed 1 ns after the rising edge, pulses drop.
    task automatic tick();
        @(posedge CLOCK);
        #1;
        START     = 1'b0;
        BTN_VALID = 1'b0;
    endtask

    task automatic press(input logic [1:0] code);
        BTN_VALID = 1'b1;
        BTN_CODE  = code;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b0; START = 1'b0; BTN_VALID = 1'b0; BTN_CODE = 2'd0;
        @(posedge CLOCK); #1;
        total++;
        if ({ROUND, SEQ_ADDR, LED_VALID, LED_CODE, BUSY, WIN, LOSE} !== 15'd0) begin
            bad++;
            $display("FAIL reset: round=%0d addr=%0d led=%b code=%0d busy=%b win=%b lose=%b want all 0",
                     ROUND, SEQ_ADDR, LED_VALID, LED_CODE, BUSY, WIN, LOSE);
        end
        RESET = 1'b1;
        press(2'd2);  // presses in IDLE are ignored
        tick();
        total++;
        if ({ROUND, LED_VALID, BUSY, WIN, LOSE} !== 8'd0) begin
            bad++;
            $display("FAIL idle_hold: round=%0d led=%b busy=%b win=%b lose=%b want all 0",
                     ROUND, LED_VALID, BUSY, WIN, LOSE);
        end
    endtask

    task automatic test_first_playback();
        START = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (LED_VALID !== (i < 4) || BUSY !== 1'b1 || (i < 4 && LED_CODE !== 2'd2)) begin
                bad++;
                $display("FAIL first_show c%0d: led=%b code=%0d busy=%b want led=%b code=2 busy=1",
                         i, LED_VALID, LED_CODE, BUSY, i < 4);
            end
            tick();
        end
        total++;
        if ({LED_VALID, BUSY, ROUND} !== {1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL first_wait: led=%b busy=%b round=%0d want led=0 busy=1 round=0",
                     LED_VALID, BUSY, ROUND);
        end
    endtask

    task automatic test_round_advance();
        press(2'd2);
        total++;
        if (ROUND !== 4'd1) begin
            bad++;
            $display("FAIL round0_done: round=%0d want 1", ROUND);
        end
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (LED_VALID !== (i < 4) || BUSY !== 1'b1 || (i < 4 && LED_CODE !== seq_mem[e])) begin
                    bad++;
                    $display("FAIL r1_show e%0d c%0d: led=%b code=%0d want led=%b code=%0d",
                             e, i, LED_VALID, LED_CODE, i < 4, seq_mem[e]);
                end
                tick();
            end
        end
    endtask

    task automatic test_wrong_press();
        press(2'd2);
        total++;
        if ({ROUND, LOSE, BUSY, SEQ_ADDR} !== {4'd1, 1'b0, 1'b1, 4'd1}) begin
            bad++;
            $display("FAIL r1_first_ok: round=%0d lose=%b busy=%b addr=%0d want 1/0/1/1",
                     ROUND, LOSE, BUSY, SEQ_ADDR);
        end
        press(2'd0);
        total++;
        if ({ROUND, LOSE, WIN, BUSY, LED_VALID} !== {4'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL wrong_press: round=%0d lose=%b win=%b busy=%b led=%b want 1/1/0/0/0",
                     ROUND, LOSE, WIN, BUSY, LED_VALID);
        end
        press(2'd1);
        tick();
        total++;
        if ({ROUND, LOSE, BUSY} !== {4'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL lose_hold: round=%0d lose=%b busy=%b want 1/1/0", ROUND, LOSE, BUSY);
        end
        START = 1'b1;
        tick();
        total++;
        if ({ROUND, LOSE, LED_VALID, LED_CODE, BUSY} !== {4'd0, 1'b0, 1'b1, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL restart: round=%0d lose=%b led=%b code=%0d busy=%b want 0/0/1/2/1",
                     ROUND, LOSE, LED_VALID, LED_CODE, BUSY);
        end
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        repeat (63) tick();
        total++;
        if ({LOSE, BUSY} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_early: lose=%b busy=%b at wait cycle 64 want 0/1", LOSE, BUSY);
        end
        tick();
        total++;
        if ({LOSE, BUSY, ROUND} !== {1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL timeout: lose=%b busy=%b round=%0d want 1/0/0", LOSE, BUSY, ROUND);
        end
    endtask

    task automatic test_timeout_press();
        START = 1'b1;
        tick();
        repeat (6) tick();
        repeat (63) tick();
        press(2'd2);
        total++;
        if ({ROUND, LOSE, LED_VALID, LED_CODE} !== {4'd1, 1'b0, 1'b1, 2'd2}) begin
            bad++;
            $display("FAIL press_at_expiry: round=%0d lose=%b led=%b code=%0d want 1/0/1/2",
                     ROUND, LOSE, LED_VALID, LED_CODE);
        end
        repeat (12) tick();
    endtask

    task automatic test_win();
        press(2'd2);
        press(2'd1);
        total++;
        if ({ROUND, WIN, BUSY} !== {4'd2, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL round1_done: round=%0d win=%b busy=%b want 2/0/1", ROUND, WIN, BUSY);
        end
        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (LED_VALID !== (i < 4) || BUSY !== 1'b1 || (i < 4 && LED_CODE !== seq_mem[e])) begin
                    bad++;
                    $display("FAIL r2_show e%0d c%0d: led=%b code=%0d want led=%b code=%0d",
                             e, i, LED_VALID, LED_CODE, i < 4, seq_mem[e]);
                end
                tick();
            end
        end
        press(2'd2);
        press(2'd1);
        press(2'd3);
        total++;
        if ({ROUND, WIN, LOSE, BUSY, LED_VALID} !== {4'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL win: round=%0d win=%b lose=%b busy=%b led=%b want 3/1/0/0/0",
                     ROUND, WIN, LOSE, BUSY, LED_VALID);
        end
        press(2'd0);
        press(2'd2);
        total++;
        if ({ROUND, WIN, LOSE, BUSY} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL win_hold: round=%0d win=%b lose=%b busy=%b want 3/1/0/0",
                     ROUND, WIN, LOSE, BUSY);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        START = 1'b1;
        tick();
        START = 1'b1;  // mid-playback restart request must not stretch the lit window
        tick();
        repeat (2) tick();
        total++;
        if ({LED_VALID, ROUND, WIN} !== {1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL start_mid_on: led=%b round=%0d win=%b want 1/0/0", LED_VALID, ROUND, WIN);
        end
        tick();
        total++;
        if ({LED_VALID, BUSY} !== 2'b01) begin
            bad++;
            $display("FAIL start_mid_off: led=%b busy=%b want 0/1", LED_VALID, BUSY);
        end
        repeat (2) tick();
        press(2'd2);
        #2 RESET = 1'b0;
        #1;
        total++;
        if ({ROUND, SEQ_ADDR, LED_VALID, LED_CODE, BUSY, WIN, LOSE} !== 15'd0) begin
            bad++;
            $display("FAIL async_reset: round=%0d addr=%0d led=%b code=%0d busy=%b want all 0",
                     ROUND, SEQ_ADDR, LED_VALID, LED_CODE, BUSY);
        end
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        repeat (2) tick();
        total++;
        if ({ROUND, LED_VALID, BUSY, WIN, LOSE} !== 8'd0) begin
            bad++;
            $display("FAIL post_reset: round=%0d led=%b busy=%b win=%b lose=%b want all 0",
                     ROUND, LED_VALID, BUSY, WIN, LOSE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        seq_mem = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3,
                    2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
        test_reset();
        test_first_playback();
        test_round_advance();
        test_wrong_press();
        test_timeout();
        test_timeout_press();
        test_win();
        test_start_ignored_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/genius_round_ctrl.md
Name: genius_round_ctrl

Overview:
- Round controller for the Genius (Simon) game; sits directly upstream of the scoring stage and drives its ROUND input.
- Plays back the colour sequence from an external sequence memory.
- Checks player button presses against that sequence and counts completed rounds.
- Flags WIN or LOSE. ROUND holds after game end so the downstream score (level × rounds) stays stable.

Parameters:
- MAX_ROUND, 15: completed rounds needed to win; legal range 1..15.
- SHOW_ON, 4: cycles each sequence element is lit during playback; ≥1.
- SHOW_OFF, 2: dark gap cycles after each lit element; ≥1.
- TIMEOUT_CYCLES, 64: cycles allowed between presses in WAIT_INPUT; ≥2.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle start/restart request.
- SEQ_ADDR  out  4  index into the sequence memory.
- SEQ_DATA  in  2  colour at SEQ_ADDR; combinational read, valid in the same cycle.
- BTN_VALID  in  1  single-cycle pulse: player pressed a button.
- BTN_CODE  in  2  colour of the pressed button, qualified by BTN_VALID.
- LED_VALID  out  1  playback LED on.
- LED_CODE  out  2  colour being shown.
- ROUND  out  4  completed rounds; feeds the scoring stage.
- BUSY  out  1  high in SHOW and WAIT_INPUT.
- WIN  out  1  sticky; set on reaching MAX_ROUND.
- LOSE  out  1  sticky; set on wrong press or timeout.

Behaviour:
- All outputs are registered. Internal signals: IDX (4b), TIMER (≥7b). SEQ_ADDR = IDX.
- Reset (RESET=0, async): state IDLE; ROUND=0, IDX=0, TIMER=0, LED_VALID=0, LED_CODE=0, BUSY=0, WIN=0, LOSE=0.
- States: IDLE, SHOW_ON_S, SHOW_OFF_S, WAIT_INPUT, DONE.
- Sequence length in round r is r+1 elements, indices 0..r, where r = ROUND.
- IDLE and DONE:
  - START=1 → ROUND=0, IDX=0, TIMER=0, WIN=0, LOSE=0; next state SHOW_ON_S.
  - START is ignored in every other state.
- SHOW_ON_S:
  - LED_VALID=1 and LED_CODE=SEQ_DATA, registered on state entry.
  - After SHOW_ON cycles → SHOW_OFF_S with LED_VALID=0; TIMER restarts.
- SHOW_OFF_S:
  - After SHOW_OFF cycles: if IDX==ROUND → IDX=0, TIMER=0, go to WAIT_INPUT.
  - Otherwise IDX+1 and return to SHOW_ON_S.
- WAIT_INPUT, press with BTN_VALID=1 and BTN_CODE==SEQ_DATA (match):
  - If IDX<ROUND: IDX+1, TIMER=0.
  - If IDX==ROUND: ROUND+1.
    - If the new ROUND==MAX_ROUND: WIN=1, go to DONE.
    - Otherwise IDX=0, TIMER=0, go to SHOW_ON_S.
- WAIT_INPUT, press with mismatch: LOSE=1, go to DONE; ROUND unchanged.
- WAIT_INPUT, no press: TIMER increments. When TIMER==TIMEOUT_CYCLES-1 with no press, LOSE=1 and go to DONE.
- Press in the same cycle as timeout expiry: the press is evaluated; the timeout is discarded.
- BTN_VALID outside WAIT_INPUT is ignored.
- Latency: a press sampled in cycle N updates ROUND/WIN/LOSE/state at the edge ending cycle N, so the new values are visible in cycle N+1.
- DONE: BUSY=0, LED_VALID=0. ROUND, WIN and LOSE hold until START or reset.
- ROUND never exceeds MAX_ROUND and never wraps.
- Reset mid-operation immediately forces the reset values, including during playback with the LED lit.
- BUSY=1 exactly in SHOW_ON_S, SHOW_OFF_S and WAIT_INPUT.

Test Plan:
- Reset then START, SEQ mem = {2,1,3,0,…} → first playback LED_VALID=1, LED_CODE=2 for 4 cycles, then 2 dark cycles, then WAIT_INPUT with ROUND=0.
- Round 0: press BTN_CODE=2 → ROUND=1 next cycle. Playback then shows 2 then 1 (two lit windows), each 4 on / 2 off.
- In WAIT_INPUT with ROUND=1: press 2 then 0 → LOSE=1, ROUND stays 1, BUSY=0, state DONE. START → ROUND=0, LOSE=0, playback restarts.
- No press for 64 cycles in WAIT_INPUT → LOSE=1 exactly at the 64th cycle. A correct press on cycle 64 → no LOSE, round proceeds.
- MAX_ROUND=3, all presses correct → ROUND goes 1, 2, 3, then WIN=1 with ROUND=3 held; BTN_VALID pulses after that are ignored.
- RESET low during SHOW_ON_S with LED_VALID=1 → all outputs 0 immediately, without waiting for a clock edge; START mid-playback has no effect.
